// File: rtl/dmem_responder.sv
// Data-memory responder: accepts level-held read/write requests in IDLE,
// completes them after LATENCY edges with a one-cycle registered mem_resp pulse,
// and owns a 16-bit word array with byte-lane write enables.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  // The counter holds the number of WAIT edges still to pass before completion,
  // so LATENCY=1 completes on the first WAIT edge and keeps the same edge timing.
  localparam logic [3:0] LoadCount = 4'(LATENCY - 1);

  stateT                 state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] reqIndex;
  logic [15:0]           reqWdata;
  logic [1:0]            reqBe;
  logic                  reqWrite;
  logic                  reqLive;
  logic                  completing;
  logic                  commitWrite;
  logic                  unusedAddr;

  logic [15:0] storage [2**DEPTH_LOG2];

  // Address bits outside the word index only alias and are deliberately dropped.
  assign unusedAddr = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

  assign reqLive     = mem_read | mem_write;
  assign completing  = (state == StWait) && reqLive && (cnt == '0);
  assign commitWrite = completing && reqWrite;

  // Request FSM with registered response, read data and sticky protocol flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= 16'h0000;
      proto_err <= 1'b0;
      reqIndex  <= '0;
      reqWdata  <= '0;
      reqBe     <= '0;
      reqWrite  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          mem_resp <= 1'b0;
          if (reqLive) begin
            reqIndex <= mem_address[DEPTH_LOG2:1];
            reqWdata <= mem_wdata;
            reqBe    <= mem_byte_enable;
            // Simultaneous read+write is resolved as a write and flagged.
            reqWrite <= mem_write;
            cnt      <= LoadCount;
            state    <= StWait;
            if (mem_read && mem_write) begin
              proto_err <= 1'b1;
            end
          end
        end
        StWait: begin
          if (!reqLive) begin
            state <= StIdle;
          end else if (cnt == '0) begin
            state    <= StResp;
            mem_resp <= 1'b1;
            if (!reqWrite) begin
              mem_rdata <= storage[reqIndex];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          // Still-held request is intentionally not re-accepted here.
          mem_resp <= 1'b0;
          state    <= StIdle;
        end
        default: begin
          mem_resp <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

  // Byte-lane array write on the completion edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commitWrite) begin
      if (reqBe[0]) storage[reqIndex][7:0]  <= reqWdata[7:0];
      if (reqBe[1]) storage[reqIndex][15:8] <= reqWdata[15:8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic, checked
// by a scoreboard fed from a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned LAT = 3;
  localparam int unsigned DL2 = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;

  dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned respEdge;
    logic [15:0] data;
    logic        proto;
  } expT;

  expT         expQ[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned edgeNo = 0;
  int unsigned earliest = 0;
  logic [15:0] refMem [256];
  logic [15:0] lastRead = 16'h0000;
  logic        protoExp = 1'b0;

  always @(posedge clk) edgeNo <= edgeNo + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeNo);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && mem_resp) begin
      if (expQ.size() == 0) begin
        check("unexpected_resp", {16'h0, mem_rdata}, 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = expQ.pop_front();
        check("resp_edge", edgeNo, e.respEdge);
        check("rdata", {16'h0, mem_rdata}, {16'h0, e.data});
        check("proto_at_resp", {31'h0, proto_err}, {31'h0, e.proto});
      end
    end
  end

  task automatic idleInputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
  endtask

  // Issue one access, update the model, hold the request until mem_resp is seen.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input bit back);
    expT         e;
    int unsigned acc;
    bit          got;
    logic [7:0]  idx;
    if (!back) @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    acc = edgeNo + 1;
    if (acc < earliest) acc = earliest;
    idx = addr[8:1];
    if (wr) begin
      if (be[0]) refMem[idx][7:0]  = wd[7:0];
      if (be[1]) refMem[idx][15:8] = wd[15:8];
      if (rd) protoExp = 1'b1;
    end else begin
      lastRead = refMem[idx];
    end
    e.respEdge = acc + LAT;
    e.data     = lastRead;
    e.proto    = protoExp;
    expQ.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 4 * LAT + 20; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1'b1;
        break;
      end
    end
    check("resp_seen", {31'h0, got}, 32'h1);
    earliest = acc + LAT + 2;
    idleInputs();
  endtask

  initial begin
    logic [15:0] a;
    int unsigned acc;
    int          r;
    bit          back;
    logic        rd, wr;

    rst_n = 1'b0;
    idleInputs();
    repeat (3) @(negedge clk);
    check("reset_resp", {31'h0, mem_resp}, 32'h0);
    check("reset_rdata", {16'h0, mem_rdata}, 32'h0);
    check("reset_proto", {31'h0, proto_err}, 32'h0);
    rst_n = 1'b1;
    earliest = edgeNo + 1;

    // Basic write then back-to-back read (request held through RESP).
    access(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1);

    // Byte lanes and an empty lane mask.
    access(1'b0, 1'b1, 16'h0020, 16'hAAAA, 2'b11, 1'b0);
    access(1'b0, 1'b1, 16'h0021, 16'h5577, 2'b10, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);
    access(1'b0, 1'b1, 16'h0020, 16'h9999, 2'b00, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0);

    // Abort: write dropped one edge after accept leaves array and rdata untouched.
    access(1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 1'b0);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
    acc = edgeNo + 1;
    if (acc < earliest) acc = earliest;
    while (edgeNo < acc) @(negedge clk);
    idleInputs();
    earliest = acc + 2;
    repeat (LAT + 3) @(negedge clk);
    check("abort_rdata_hold", {16'h0, mem_rdata}, {16'h0, lastRead});
    access(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0);

    // Protocol error: read+write acts as a write and sets the sticky flag.
    access(1'b1, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 1'b0);
    check("proto_set", {31'h0, proto_err}, {31'h0, protoExp});
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);
    check("proto_sticky", {31'h0, proto_err}, {31'h0, protoExp});

    // Aliasing, then reset in the middle of a pending write.
    access(1'b0, 1'b1, 16'h0202, 16'h0F0F, 2'b11, 1'b0);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 16'h0002; mem_wdata = 16'h1111; mem_byte_enable = 2'b11;
    acc = edgeNo + 1;
    if (acc < earliest) acc = earliest;
    while (edgeNo < acc + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wait_resp", {31'h0, mem_resp}, 32'h0);
    check("rst_wait_rdata", {16'h0, mem_rdata}, 32'h0);
    check("rst_wait_proto", {31'h0, proto_err}, 32'h0);
    idleInputs();
    lastRead = 16'h0000;
    protoExp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    earliest = edgeNo + 1;
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0);

    // Randomized traffic over 16 aliased words, preloaded so contents are known.
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 2'b11, 1'b0);
    end
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      rd = (r < 4) || (r == 9);
      wr = (r >= 4);
      a = 16'($urandom);
      a[8:5] = 4'b0000;
      back = 1'($urandom_range(0, 1));
      if (!back) repeat ($urandom_range(0, 2)) @(negedge clk);
      access(rd, wr, a, 16'($urandom), 2'($urandom), back);
    end

    repeat (LAT + 3) @(negedge clk);
    check("proto_final", {31'h0, proto_err}, {31'h0, protoExp});
    check("queue_drained", expQ.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
